// File: rtl/timer_pkg.sv
// Shared timer definitions: prescaler FSM states and default register sizing.
package timer_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } timer_pscr_state_e;

  localparam int TIM_PSCR_WIDTH = 20;
  localparam int PSCR_MIN_VAL   = 2;

endpackage

// File: rtl/timer_pscr_tick.sv
// Prescaler tick generator: emits a one-cycle clock-enable every div_q cycles,
// with a valid/ready reload that swaps the ratio only at a period boundary.
module timer_pscr_tick
  import timer_pkg::*;
#(
  parameter int WIDTH   = TIM_PSCR_WIDTH,
  parameter int MIN_VAL = PSCR_MIN_VAL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ready_o,
  output logic             div_done_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

  timer_pscr_state_e r_state;
  timer_pscr_state_e w_state_nxt;
  logic              r_rdy;
  logic [WIDTH-1:0]  r_div;
  logic [WIDTH-1:0]  r_pend;
  logic [WIDTH-1:0]  r_cnt;
  logic              r_tick;
  logic              w_tc;
  logic              w_accept;
  logic              w_apply;

  assign w_tc = (r_cnt == (r_div - WIDTH'(1)));

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      RUN: begin
        if (div_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = PEND;
        end
      end
      PEND: begin
        // Disabled divider has no period to finish, so apply immediately.
        if (!en_i || w_tc) begin
          w_apply     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Ready/done are registered from the next state so the outputs are pure flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_rdy   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == RUN);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div  <= MIN_W;
      r_pend <= MIN_W;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (en_i && w_tc) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else if (en_i) begin
        r_cnt  <= r_cnt + WIDTH'(1);
        r_tick <= 1'b0;
      end else begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end
      if (w_accept) begin
        r_pend <= (div_i < MIN_W) ? MIN_W : div_i;
      end
      // Apply always coincides with a counter clear (TC or disabled).
      if (w_apply) begin
        r_div <= r_pend;
      end
    end
  end

  assign div_ready_o = r_rdy;
  assign div_done_o  = r_rdy;
  assign tick_o      = r_tick;
  assign cnt_o       = r_cnt;

endmodule
